// File: rtl/pipe_pkg.sv
// Shared widths, control-bundle layout, ALU op codes and forwarding-select
// encoding for the ID/EX stage and its operand forwarding muxes.
package pipe_pkg;

  localparam int DW     = 32;
  localparam int AW     = 5;
  localparam int CTRL_W = 10;

  localparam int CTRL_REG_WRITE  = 9;
  localparam int CTRL_MEM_READ   = 8;
  localparam int CTRL_MEM_WRITE  = 7;
  localparam int CTRL_MEM_TO_REG = 6;
  localparam int CTRL_ALU_SRC    = 5;
  localparam int CTRL_REG_DST    = 4;
  localparam int CTRL_ALU_OP_MSB = 3;
  localparam int CTRL_ALU_OP_LSB = 0;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_NOR = 4'd5,
    ALU_SLT = 4'd6,
    ALU_SLL = 4'd7,
    ALU_SRL = 4'd8,
    ALU_SRA = 4'd9,
    ALU_LUI = 4'd10
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_e;

  // Everything latched into EX; an all-zero value is a bubble.
  typedef struct packed {
    logic              valid;
    logic [DW-1:0]     pc;
    logic [CTRL_W-1:0] ctrl;
    logic [AW-1:0]     rs;
    logic [AW-1:0]     rt;
    logic [AW-1:0]     wt_addr;
    logic [DW-1:0]     rdata_a;
    logic [DW-1:0]     rdata_b;
    logic [DW-1:0]     imm;
  } ex_regs_t;

  // A producer feeds a consumer only for a real destination (never $0).
  function automatic logic regs_match(input logic [AW-1:0] dst, input logic [AW-1:0] src);
    return (dst != '0) && (dst == src);
  endfunction

endpackage

// File: rtl/fwd_mux.sv
// Operand forwarding for one EX source register: chooses between the EX/MEM
// ALU result, the MEM/WB write-back data and the value latched from the
// register file, with the younger stage taking priority.
module fwd_mux
  import pipe_pkg::*;
(
  input  logic [AW-1:0] src_i,
  input  logic [DW-1:0] rf_data_i,
  input  logic          exmem_reg_write_i,
  input  logic          exmem_mem_to_reg_i,
  input  logic [AW-1:0] exmem_wt_addr_i,
  input  logic [DW-1:0] exmem_result_i,
  input  logic          wb_reg_write_i,
  input  logic [AW-1:0] wb_wt_addr_i,
  input  logic [DW-1:0] wb_wt_data_i,
  output logic [DW-1:0] data_o
);

  fwd_sel_e sel;

  // Loads in EX/MEM have no data yet, so only ALU results bypass from there.
  always_comb begin
    sel = FWD_RF;
    if (exmem_reg_write_i && !exmem_mem_to_reg_i && regs_match(exmem_wt_addr_i, src_i)) begin
      sel = FWD_MEM;
    end else if (wb_reg_write_i && regs_match(wb_wt_addr_i, src_i)) begin
      sel = FWD_WB;
    end
  end

  // Steer the selected source onto the operand.
  always_comb begin
    data_o = rf_data_i;
    case (sel)
      FWD_MEM: data_o = exmem_result_i;
      FWD_WB:  data_o = wb_wt_data_i;
      default: data_o = rf_data_i;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register of the 5-stage MIPS core: latches decode outputs,
// detects load-use hazards (stalling IF/ID and inserting a bubble), squashes
// the decode slot on a taken branch and forwards EX operands.
// Optional build macro ID_EX_PERF_EN adds stall/flush cycle counters.
module id_ex_stage
  import pipe_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [DW-1:0]     id_pc,
  input  logic [DW-1:0]     id_rdata_a,
  input  logic [DW-1:0]     id_rdata_b,
  input  logic [AW-1:0]     id_rs,
  input  logic [AW-1:0]     id_rt,
  input  logic [AW-1:0]     id_rd,
  input  logic [DW-1:0]     id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              flush,
  input  logic              exmem_reg_write,
  input  logic              exmem_mem_to_reg,
  input  logic [AW-1:0]     exmem_wt_addr,
  input  logic [DW-1:0]     exmem_result,
  input  logic              wb_L_S,
  input  logic [AW-1:0]     wb_Wt_addr,
  input  logic [DW-1:0]     wb_wt_data,
  output logic              stall,
  output logic              ex_valid,
  output logic [DW-1:0]     ex_pc,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [AW-1:0]     ex_rs,
  output logic [AW-1:0]     ex_rt,
  output logic [AW-1:0]     ex_wt_addr,
  output logic [DW-1:0]     ex_op_a,
  output logic [DW-1:0]     ex_op_b,
  output logic [DW-1:0]     ex_alu_b
`ifdef ID_EX_PERF_EN
  ,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_flush_cnt
`endif
);

  ex_regs_t ex_q, ex_d;
  logic     load_use;

  // A load in EX cannot supply its data in time; rt is compared even when unused.
  always_comb begin
    load_use = ex_q.valid && ex_q.ctrl[CTRL_MEM_READ] && id_valid &&
               (regs_match(ex_q.wt_addr, id_rs) || regs_match(ex_q.wt_addr, id_rt));
  end

  assign stall = load_use;

  // Next EX contents: a bubble on flush or stall, otherwise the decode slot.
  always_comb begin
    ex_d = '0;
    if (!flush && !load_use) begin
      ex_d.valid   = id_valid;
      ex_d.pc      = id_pc;
      ex_d.ctrl    = id_valid ? id_ctrl : '0;
      ex_d.rs      = id_rs;
      ex_d.rt      = id_rt;
      ex_d.wt_addr = id_ctrl[CTRL_REG_DST] ? id_rd : id_rt;
      ex_d.rdata_a = id_rdata_a;
      ex_d.rdata_b = id_rdata_b;
      ex_d.imm     = id_imm;
    end
  end

  // Pipeline register with synchronous reset to a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  fwd_mux u_fwd_a (
    .src_i              (ex_q.rs),
    .rf_data_i          (ex_q.rdata_a),
    .exmem_reg_write_i  (exmem_reg_write),
    .exmem_mem_to_reg_i (exmem_mem_to_reg),
    .exmem_wt_addr_i    (exmem_wt_addr),
    .exmem_result_i     (exmem_result),
    .wb_reg_write_i     (wb_L_S),
    .wb_wt_addr_i       (wb_Wt_addr),
    .wb_wt_data_i       (wb_wt_data),
    .data_o             (ex_op_a)
  );

  fwd_mux u_fwd_b (
    .src_i              (ex_q.rt),
    .rf_data_i          (ex_q.rdata_b),
    .exmem_reg_write_i  (exmem_reg_write),
    .exmem_mem_to_reg_i (exmem_mem_to_reg),
    .exmem_wt_addr_i    (exmem_wt_addr),
    .exmem_result_i     (exmem_result),
    .wb_reg_write_i     (wb_L_S),
    .wb_wt_addr_i       (wb_Wt_addr),
    .wb_wt_data_i       (wb_wt_data),
    .data_o             (ex_op_b)
  );

  assign ex_valid   = ex_q.valid;
  assign ex_pc      = ex_q.pc;
  assign ex_ctrl    = ex_q.ctrl;
  assign ex_rs      = ex_q.rs;
  assign ex_rt      = ex_q.rt;
  assign ex_wt_addr = ex_q.wt_addr;
  assign ex_alu_b   = ex_q.ctrl[CTRL_ALU_SRC] ? ex_q.imm : ex_op_b;

`ifdef ID_EX_PERF_EN
  logic [31:0] perf_stall_q, perf_flush_q;

  // Independent free-running counts of stall and flush cycles; both may step together.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (load_use) perf_stall_q <= perf_stall_q + 32'd1;
      if (flush)    perf_flush_q <= perf_flush_q + 32'd1;
    end
  end

  assign perf_stall_cnt = perf_stall_q;
  assign perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: expected EX contents are pushed to a
// scoreboard queue when a decode slot is driven and popped after the edge.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [31:0] id_pc, id_rdata_a, id_rdata_b, id_imm;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [9:0]  id_ctrl;
  logic        flush;
  logic        exmem_reg_write, exmem_mem_to_reg;
  logic [4:0]  exmem_wt_addr;
  logic [31:0] exmem_result;
  logic        wb_L_S;
  logic [4:0]  wb_Wt_addr;
  logic [31:0] wb_wt_data;
  logic        stall, ex_valid;
  logic [31:0] ex_pc, ex_op_a, ex_op_b, ex_alu_b;
  logic [9:0]  ex_ctrl;
  logic [4:0]  ex_rs, ex_rt, ex_wt_addr;
`ifdef ID_EX_PERF_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt;
  int          mStallCnt = 0;
  int          mFlushCnt = 0;
`endif

  localparam logic [9:0] CTRL_LW   = 10'h360;
  localparam logic [9:0] CTRL_ADD  = 10'h210;
  localparam logic [9:0] CTRL_IMMD = 10'h230;

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic [9:0]  ctrl;
    logic [4:0]  rs, rt, wt;
    logic [31:0] a, b, imm;
  } exStage_t;

  exStage_t expQ[$];
  exStage_t mdl;
  int       checks = 0;
  int       errors = 0;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
    .id_rdata_a(id_rdata_a), .id_rdata_b(id_rdata_b),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_imm(id_imm), .id_ctrl(id_ctrl),
    .flush(flush), .exmem_reg_write(exmem_reg_write), .exmem_mem_to_reg(exmem_mem_to_reg),
    .exmem_wt_addr(exmem_wt_addr), .exmem_result(exmem_result),
    .wb_L_S(wb_L_S), .wb_Wt_addr(wb_Wt_addr), .wb_wt_data(wb_wt_data),
    .stall(stall), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_ctrl(ex_ctrl),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_wt_addr(ex_wt_addr),
    .ex_op_a(ex_op_a), .ex_op_b(ex_op_b), .ex_alu_b(ex_alu_b)
`ifdef ID_EX_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference forwarding: younger EX/MEM ALU result first, then WB, never $0.
  function automatic logic [31:0] fwdRef(input logic [4:0] src, input logic [31:0] rf);
    if (exmem_reg_write && !exmem_mem_to_reg && exmem_wt_addr != 5'd0 && exmem_wt_addr == src)
      return exmem_result;
    if (wb_L_S && wb_Wt_addr != 5'd0 && wb_Wt_addr == src)
      return wb_wt_data;
    return rf;
  endfunction

  task automatic setFwd(input logic xr, input logic xm, input logic [4:0] xw, input logic [31:0] xd,
                        input logic wl, input logic [4:0] ww, input logic [31:0] wd);
    exmem_reg_write = xr; exmem_mem_to_reg = xm; exmem_wt_addr = xw; exmem_result = xd;
    wb_L_S = wl; wb_Wt_addr = ww; wb_wt_data = wd;
    #1;
  endtask

  task automatic checkEx();
    checkOutput("exValid", 32'(ex_valid), 32'(mdl.valid));
    checkOutput("exCtrl", 32'(ex_ctrl), 32'(mdl.ctrl));
    checkOutput("exPc", ex_pc, mdl.pc);
    checkOutput("exRs", 32'(ex_rs), 32'(mdl.rs));
    checkOutput("exRt", 32'(ex_rt), 32'(mdl.rt));
    checkOutput("exWt", 32'(ex_wt_addr), 32'(mdl.wt));
    checkOutput("opA", ex_op_a, mdl.a);
    checkOutput("opB", ex_op_b, mdl.b);
    checkOutput("aluB", ex_alu_b, mdl.ctrl[5] ? mdl.imm : mdl.b);
`ifdef ID_EX_PERF_EN
    checkOutput("perfStall", perf_stall_cnt, 32'(mStallCnt));
    checkOutput("perfFlush", perf_flush_cnt, 32'(mFlushCnt));
`endif
  endtask

  // Drive one decode slot, check stall, push the expected EX result, check after the edge.
  task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic [31:0] ra,
                               input logic [31:0] rb, input logic [31:0] imm,
                               input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                               input logic [9:0] ctrl, input logic fl);
    exStage_t nxt;
    logic     expStall;
    @(negedge clk);
    id_valid = v; id_pc = pc; id_rdata_a = ra; id_rdata_b = rb; id_imm = imm;
    id_rs = rs; id_rt = rt; id_rd = rd; id_ctrl = ctrl; flush = fl;
    setFwd(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    expStall = mdl.valid && mdl.ctrl[8] && mdl.wt != 5'd0 && v && (mdl.wt == rs || mdl.wt == rt);
    checkOutput("stall", 32'(stall), 32'(expStall));
    nxt = '{valid: 1'b0, pc: 32'd0, ctrl: 10'd0, rs: 5'd0, rt: 5'd0, wt: 5'd0,
            a: 32'd0, b: 32'd0, imm: 32'd0};
    if (!fl && !expStall) begin
      nxt.valid = v; nxt.pc = pc; nxt.ctrl = v ? ctrl : 10'd0;
      nxt.rs = rs; nxt.rt = rt; nxt.wt = ctrl[4] ? rd : rt;
      nxt.a = ra; nxt.b = rb; nxt.imm = imm;
    end
`ifdef ID_EX_PERF_EN
    if (expStall) mStallCnt++;
    if (fl) mFlushCnt++;
`endif
    expQ.push_back(nxt);
    @(posedge clk);
    #1;
    mdl = expQ.pop_front();
    checkEx();
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    id_valid = 1'b1; id_pc = 0; id_rdata_a = 0; id_rdata_b = 0; id_imm = 0;
    id_rs = 0; id_rt = 0; id_rd = 0; id_ctrl = 0;
    exmem_reg_write = 0; exmem_mem_to_reg = 0; exmem_wt_addr = 0; exmem_result = 0;
    wb_L_S = 0; wb_Wt_addr = 0; wb_wt_data = 0;
    mdl = '{valid: 1'b0, pc: 32'd0, ctrl: 10'd0, rs: 5'd0, rt: 5'd0, wt: 5'd0,
            a: 32'd0, b: 32'd0, imm: 32'd0};

    // Reset held for two cycles while decode presents random valid slots.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      id_pc = $urandom; id_rdata_a = $urandom; id_rdata_b = $urandom; id_imm = $urandom;
      id_rs = 5'($urandom); id_rt = 5'($urandom); id_rd = 5'($urandom); id_ctrl = 10'($urandom);
      @(posedge clk);
      #1;
      checkOutput("rstValid", 32'(ex_valid), 32'd0);
      checkOutput("rstCtrl", 32'(ex_ctrl), 32'd0);
      checkOutput("rstPc", ex_pc, 32'd0);
      checkOutput("rstWt", 32'(ex_wt_addr), 32'd0);
      checkOutput("rstOpA", ex_op_a, 32'd0);
      checkOutput("rstAluB", ex_alu_b, 32'd0);
      checkOutput("rstStall", 32'(stall), 32'd0);
    end
    rst = 1'b0;

    // lw $8 is the first instruction after reset; add $9,$8,$1 stalls once.
    applyStimulus(1, 32'h100, 32'h40, 32'h0, 32'h4, 5'd2, 5'd8, 5'd0, CTRL_LW, 0);
    applyStimulus(1, 32'h104, 32'hDEAD, 32'h99, 32'h0, 5'd8, 5'd1, 5'd9, CTRL_ADD, 0);
    checkOutput("bubbleValid", 32'(ex_valid), 32'd0);
    applyStimulus(1, 32'h104, 32'hDEAD, 32'h99, 32'h0, 5'd8, 5'd1, 5'd9, CTRL_ADD, 0);
    setFwd(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 32'h1234);
    checkOutput("luWbOpA", ex_op_a, 32'h1234);
    checkOutput("luWbOpB", ex_op_b, 32'h99);

    // Both bypass stages target $3: younger EX/MEM wins unless it is a load.
    applyStimulus(1, 32'h108, 32'h11, 32'h22, 32'h0, 5'd3, 5'd3, 5'd4, CTRL_ADD, 0);
    setFwd(1'b1, 1'b0, 5'd3, 32'hAAAA, 1'b1, 5'd3, 32'h5555);
    checkOutput("prioOpA", ex_op_a, 32'hAAAA);
    checkOutput("prioOpB", ex_op_b, 32'hAAAA);
    setFwd(1'b1, 1'b1, 5'd3, 32'hAAAA, 1'b1, 5'd3, 32'h5555);
    checkOutput("m2rOpA", ex_op_a, 32'h5555);
    checkOutput("m2rOpB", ex_op_b, 32'h5555);

    // Register 0: never forwarded, and a load to $0 never stalls.
    applyStimulus(1, 32'h10C, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, CTRL_LW, 0);
    applyStimulus(1, 32'h110, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd5, CTRL_ADD, 0);
    checkOutput("r0Valid", 32'(ex_valid), 32'd1);
    setFwd(1'b1, 1'b0, 5'd0, 32'hFFFF, 1'b1, 5'd0, 32'h777);
    checkOutput("r0OpA", ex_op_a, 32'd0);
    checkOutput("r0OpB", ex_op_b, 32'd0);

    // Flush and load-use in the same cycle: flush squashes, stall still reported.
    applyStimulus(1, 32'h114, 32'h40, 32'h0, 32'h8, 5'd2, 5'd8, 5'd0, CTRL_LW, 0);
    applyStimulus(1, 32'h118, 32'h1, 32'h2, 32'h0, 5'd8, 5'd1, 5'd9, CTRL_ADD, 1);
    checkOutput("flushValid", 32'(ex_valid), 32'd0);
    checkOutput("flushCtrl", 32'(ex_ctrl), 32'd0);

    // Immediate operand and rd destination.
    applyStimulus(1, 32'h11C, 32'h3, 32'h7, 32'hFFFFFFFC, 5'd6, 5'd5, 5'd12, CTRL_IMMD, 0);
    checkOutput("immAluB", ex_alu_b, 32'hFFFFFFFC);
    checkOutput("immOpB", ex_op_b, 32'h7);
    checkOutput("immWt", 32'(ex_wt_addr), 32'd12);

    // Random decode slots over a small register set to provoke hazards and bypasses.
    for (int i = 0; i < 40; i++) begin
      logic [9:0] c;
      c = 10'($urandom);
      if (($urandom % 3) == 0) c = CTRL_LW;
      applyStimulus(($urandom % 6) != 0, $urandom, $urandom, $urandom, $urandom,
                    5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    c, ($urandom % 8) == 0);
      setFwd(1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)), $urandom,
             1'($urandom), 5'($urandom_range(0, 3)), $urandom);
      checkOutput("rndOpA", ex_op_a, fwdRef(mdl.rs, mdl.a));
      checkOutput("rndOpB", ex_op_b, fwdRef(mdl.rt, mdl.b));
      checkOutput("rndAluB", ex_alu_b, mdl.ctrl[5] ? mdl.imm : fwdRef(mdl.rt, mdl.b));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline stage of the 5-stage MIPS core, directly downstream of the register file.
- Latches decode outputs (rdata_A/rdata_B, register numbers, immediate, control) into EX.
- Detects load-use hazards and stalls IF/ID; inserts bubbles on stall or branch flush.
- Produces forwarded EX operands from the EX/MEM and MEM/WB bypass paths.

Parameters:
- DW, 32, datapath width.
- AW, 5, register-number width.
- CTRL_W, 10, control bundle width: reg_write, mem_read, mem_write, mem_to_reg, alu_src, reg_dst, alu_op[3:0].

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- id_valid  in  1  decode slot holds a real instruction.
- id_pc  in  DW  decode PC.
- id_rdata_a, id_rdata_b  in  DW  register file read data.
- id_rs, id_rt, id_rd  in  AW  register numbers.
- id_imm  in  DW  sign/zero-extended immediate.
- id_ctrl  in  CTRL_W  decode control bundle.
- flush  in  1  taken branch/jump resolved in EX; kill decode slot.
- exmem_reg_write, exmem_mem_to_reg  in  1  EX/MEM control.
- exmem_wt_addr  in  AW; exmem_result  in  DW  EX/MEM ALU result.
- wb_L_S  in  1; wb_Wt_addr  in  AW; wb_wt_data  in  DW  write-back port (same nets driving the register file).
- stall  out  1  hold PC and IF/ID this cycle.
- ex_valid  out  1; ex_pc  out  DW; ex_ctrl  out  CTRL_W.
- ex_rs, ex_rt  out  AW; ex_wt_addr  out  AW  rd if reg_dst else rt.
- ex_op_a  out  DW  forwarded rs value.
- ex_op_b  out  DW  forwarded rt value (store data).
- ex_alu_b  out  DW  id_imm-captured value if alu_src else ex_op_b.

Behaviour:
- Reset: all registered outputs 0 (ex_valid=0, ex_ctrl=0 = bubble); stall therefore 0.
- Register file writes on falling edge; ID reads already see same-cycle WB writes, so no ID-side bypass.
- Load-use stall (combinational):
  - stall = ex_valid & ex_ctrl.mem_read & ex_wt_addr!=0 & id_valid & (ex_wt_addr==id_rs | ex_wt_addr==id_rt).
  - rt is compared conservatively regardless of instruction type.
- Rising-edge update priority: rst > flush > stall > load.
  - flush or stall: bubble; ex_valid=0, ex_ctrl=0, ex_wt_addr=0, data fields 0.
  - flush and stall together: flush wins; stall output is still driven as computed.
  - Otherwise: capture all id_* fields; ex_valid=id_valid; ex_ctrl=id_valid?id_ctrl:0.
- Forwarding (combinational, per operand; src = ex_rs for A, ex_rt for B):
  - EX/MEM if exmem_reg_write & !exmem_mem_to_reg & exmem_wt_addr!=0 & exmem_wt_addr==src. Value: exmem_result.
  - Else MEM/WB if wb_L_S & wb_Wt_addr!=0 & wb_Wt_addr==src. Value: wb_wt_data.
  - Else the latched register value.
  - Younger stage wins when both match.
  - Register 0 is never forwarded.
- Mandatory MEM/WB path: after a load-use stall, the consumer reaches EX while the load is in WB.
- Latency: ID to EX is 1 cycle; a load-use pair costs exactly 1 bubble.

Optional Feature:
- Macro ID_EX_PERF_EN.
- Defined: adds outputs perf_stall_cnt and perf_flush_cnt, each 32 bits.
  - Each increments by 1 per cycle where stall (resp. flush) is 1.
  - Wraps at 2^32-1 to 0; cleared by rst.
  - If stall and flush occur together, both counters increment.
- Undefined: ports and counters absent; no other behaviour changes.

Decomposition:
- Package pipe_pkg: DW, AW, CTRL_W; ctrl bit indices (CTRL_REG_WRITE..CTRL_ALU_OP_LSB); ALU op codes; forward-select encoding FWD_RF=0, FWD_MEM=1, FWD_WB=2.
- Sub-module fwd_mux: one operand's select logic plus 3:1 mux. Instantiated twice (A, B).

Test Plan:
- rst high 2 cycles, with id_valid=1 and random inputs -> all ex_* outputs 0, stall=0; first load after rst release is captured.
- lw $8 in EX (mem_read=1, ex_wt_addr=8), ID add $9,$8,$1 -> stall=1 for 1 cycle, then bubble in EX (ex_valid=0). Next cycle add enters EX with wb_L_S=1, wb_Wt_addr=8, wb_wt_data=0x1234 -> ex_op_a=0x1234.
- EX/MEM writes $3=0xAAAA and MEM/WB writes $3=0x5555, EX rs=rt=3 -> ex_op_a=ex_op_b=0xAAAA. If exmem_mem_to_reg=1 instead -> 0x5555.
- exmem_wt_addr=0 with exmem_reg_write=1, result 0xFFFF, ex_rs=0, latched value 0 -> ex_op_a=0; lw to $0 in EX -> stall=0.
- flush=1 and stall condition true in the same cycle -> next ex_valid=0, ex_ctrl=0. With ID_EX_PERF_EN: perf_flush_cnt and perf_stall_cnt each +1.
- alu_src=1, id_imm=0xFFFFFFFC, id_rdata_b=7 -> ex_alu_b=0xFFFFFFFC, ex_op_b=7. reg_dst=1, rd=12, rt=5 -> ex_wt_addr=12.
